frame_packer: RTL

FRAME_PACKER -- requirements
Module: frame_packer

---
 rtl/fifo_package.sv | 12 +
 rtl/frame_packer_if.sv | 29 ++
 rtl/frame_packer.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_package.sv
// Shared definitions for the frame packer: payload width and FSM state encoding.
package fifo_package;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PAYLOAD  = 2'd1,
        CHECKSUM = 2'd2
    } fp_state_e;

endpackage

// File: rtl/frame_packer_if.sv
// Bundles the upstream and downstream handshakes of frame_packer for benches and wrappers.
interface frame_packer_if
    import fifo_package::*;
#(
    parameter int DW = DATA_WIDTH
);

    // A beat moves on a rising edge where its valid and the opposite side's grant are both 1;
    // a sender holds data/valid (and last) stable until that edge.
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          grant_out;
    logic          flush;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          last_out;
    logic          grant_in;

    modport master (
        output data_in, valid_in, flush, grant_in,
        input  grant_out, data_out, valid_out, last_out
    );

    modport slave (
        input  data_in, valid_in, flush, grant_in,
        output grant_out, data_out, valid_out, last_out
    );

endinterface

// File: rtl/frame_packer.sv
// Packs upstream words into frames of FRAME_LEN payload beats followed by an XOR checksum beat.
module frame_packer #(
    parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
    parameter int FRAME_LEN  = 4,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic                       valid_i,
    output logic                       grant_o,
    input  logic                       flush_i,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       valid_o,
    output logic                       last_o,
    input  logic                       grant_i,
    output logic [FCNT_WIDTH-1:0]      frame_cnt_o,
    output fifo_package::fp_state_e    state_o
);

    import fifo_package::*;

    localparam logic [7:0] LEN = 8'(FRAME_LEN);

    fp_state_e               state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   csum_q, csum_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [FCNT_WIDTH-1:0]   fcnt_q, fcnt_d;

    logic       out_free;
    logic       in_xfer;
    logic [7:0] cnt_inc;

    assign out_free = !valid_q || grant_i;
    assign grant_o  = !rst && (state_q != CHECKSUM) && out_free;
    assign in_xfer  = valid_i && grant_o;
    assign cnt_inc  = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        fcnt_d  = fcnt_q;

        if (valid_q && grant_i && last_q) begin
            fcnt_d = fcnt_q + 1'b1;
        end

        // A consumed beat empties the register unless something reloads it below.
        if (out_free) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        unique case (state_q)
            IDLE, PAYLOAD: begin
                if (in_xfer) begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    csum_d  = csum_q ^ data_i;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == LEN || flush_i) ? CHECKSUM : PAYLOAD;
                end else if (state_q == PAYLOAD && flush_i) begin
                    state_d = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (out_free) begin
                    data_d  = csum_q;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    csum_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign last_o      = last_q;
    assign frame_cnt_o = fcnt_q;
    assign state_o     = state_q;

endmodule
